ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- RV32I execute stage with optional iterative RV32M unit.
//
// Executes OP, OP-IMM and LUI in one cycle. Everything else that arrives
// valid produces a non-writing result slot. With RV32M_EN defined, M ops
// (OP, funct7=0000001) run on a 32-iteration shift-add / restoring-divide
// engine and hold the front end through stall_o. With RV32M_EN undefined,
// M ops retire in one cycle flagged illegal and stall_o is tied low.
//
// Configuration macro: RV32M_EN (M-extension support).
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   valid_i     decoded op present in the ID/EX register
//   rd_i        destination register index
//   imm_ext_i   sign-extended immediate
//   rs1_data_i  source operand 1
//   rs2_data_i  source operand 2
//   opcode_i    major opcode
//   funct3_i    funct3 field
//   funct7_i    funct7 field
//   stall_o     hold ID/EX and upstream (combinational)
//   valid_o     registered result slot valid
//   rd_o        registered destination index
//   result_o    registered result
//   wb_en_o     registered register-file write enable
//   illegal_o   registered illegal-instruction flag
// ---------------------------------------------------------------------------
module ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] imm_ext_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   output logic        stall_o,
   output logic        valid_o,
   output logic [4:0]  rd_o,
   output logic [31:0] result_o,
   output logic        wb_en_o,
   output logic        illegal_o
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   // ------------------------------------------------------------------
   // Decode and single-cycle ALU
   // ------------------------------------------------------------------
   logic        is_op;
   logic        is_op_imm;
   logic        is_lui;
   logic        is_m;
   logic [31:0] op_b;
   logic [4:0]  shamt;
   logic [31:0] alu_result;

   assign is_op     = (opcode_i == OPC_OP);
   assign is_op_imm = (opcode_i == OPC_OP_IMM);
   assign is_lui    = (opcode_i == OPC_LUI);
   assign is_m      = is_op && (funct7_i == F7_MULDIV);
   assign op_b      = is_op ? rs2_data_i : imm_ext_i;
   assign shamt     = op_b[4:0];

   // NOTE: every variable written in a combinational block gets a default
   // first, so no path through the case/if tree can infer a latch.
   always_comb begin
      alu_result = '0;
      unique case (funct3_i)
         3'b000: alu_result = (is_op && funct7_i[5]) ? rs1_data_i - op_b
                                                     : rs1_data_i + op_b;
         3'b001: alu_result = rs1_data_i << shamt;
         3'b010: alu_result = {31'd0, $signed(rs1_data_i) < $signed(op_b)};
         3'b011: alu_result = {31'd0, rs1_data_i < op_b};
         3'b100: alu_result = rs1_data_i ^ op_b;
         3'b101: alu_result = funct7_i[5] ? 32'($signed(rs1_data_i) >>> shamt)
                                          : rs1_data_i >> shamt;
         3'b110: alu_result = rs1_data_i | op_b;
         3'b111: alu_result = rs1_data_i & op_b;
         default: alu_result = '0;
      endcase
   end

`ifdef RV32M_EN
   // ------------------------------------------------------------------
   // Iterative multiply / divide engine
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t      state;
   state_t      nxt_state;
   logic [4:0]  count;
   logic [2:0]  m_f3;
   logic [4:0]  m_rd;
   logic        a_neg;
   logic        b_neg;
   logic        div_zero;
   logic [31:0] mag_b;       // multiplicand or divisor magnitude
   logic [63:0] p;           // {accumulator/remainder, multiplier/quotient}
   logic        start;
   logic        a_signed;
   logic        b_signed;

   assign start = valid_i && is_m;

   // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2
   // as signed. MUL's low word is sign-agnostic, so it runs unsigned.
   assign a_signed = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                     (funct3_i == 3'b100) || (funct3_i == 3'b110);
   assign b_signed = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                     (funct3_i == 3'b110);

   always_comb begin
      nxt_state = state;
      stall_o   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               stall_o   = 1'b1;
               nxt_state = S_BUSY;
            end
         end
         S_BUSY: begin
            stall_o = 1'b1;
            if (count == 5'd31) nxt_state = S_DONE;
         end
         S_DONE:  nxt_state = S_IDLE;
         default: nxt_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state always uses non-blocking assignments so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt_state;
   end

   // One shift-add step: add multiplicand to the high half when the
   // multiplier LSB is set, then shift the 65-bit sum right.
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   assign mul_sum  = {1'b0, p[63:32]} + {1'b0, (p[0] ? mag_b : 32'd0)};
   assign mul_next = {mul_sum, p[31:1]};

   // One restoring-divide step: shift the next dividend bit into the
   // remainder and subtract the divisor if it fits. The shifted remainder
   // needs 33 bits because the divisor may exceed 2^31.
   logic [32:0] rem_sh;
   logic        sub_ok;
   logic [63:0] div_next;
   assign rem_sh   = {p[63:32], p[31]};
   assign sub_ok   = (rem_sh >= {1'b0, mag_b});
   assign div_next = sub_ok ? {rem_sh[31:0] - mag_b, p[30:0], 1'b1}
                            : {rem_sh[31:0],         p[30:0], 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         m_f3     <= '0;
         m_rd     <= '0;
         a_neg    <= 1'b0;
         b_neg    <= 1'b0;
         div_zero <= 1'b0;
         mag_b    <= '0;
         p        <= '0;
      end else if (state == S_IDLE && start) begin
         count    <= '0;
         m_f3     <= funct3_i;
         m_rd     <= rd_i;
         a_neg    <= a_signed && rs1_data_i[31];
         b_neg    <= b_signed && rs2_data_i[31];
         div_zero <= (rs2_data_i == 32'd0);
         mag_b    <= (b_signed && rs2_data_i[31]) ? -rs2_data_i : rs2_data_i;
         p        <= {32'd0, (a_signed && rs1_data_i[31]) ? -rs1_data_i
                                                          : rs1_data_i};
      end else if (state == S_BUSY) begin
         count <= count + 5'd1;
         p     <= m_f3[2] ? div_next : mul_next;
      end
   end

   // Sign correction. A zero divisor yields an all-ones quotient and a
   // remainder equal to the dividend (which the magnitude path already
   // gives once the dividend sign is restored). Signed overflow falls out
   // naturally: 2^31 / 1 with equal signs is 0x80000000, remainder 0.
   logic [63:0] prod;
   logic [31:0] quot;
   logic [31:0] rem;
   logic [31:0] m_result;
   assign prod = (a_neg ^ b_neg) ? -p : p;
   assign quot = div_zero ? 32'hFFFF_FFFF
                          : ((a_neg ^ b_neg) ? -p[31:0] : p[31:0]);
   assign rem  = a_neg ? -p[63:32] : p[63:32];

   always_comb begin
      m_result = '0;
      if (!m_f3[2]) m_result = (m_f3[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
      else          m_result = m_f3[1] ? rem : quot;
   end
`else
   assign stall_o = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Output register next-state
   // ------------------------------------------------------------------
   logic        nxt_valid;
   logic [4:0]  nxt_rd;
   logic [31:0] nxt_result;
   logic        nxt_wb;
   logic        nxt_illegal;

   always_comb begin
      nxt_valid   = 1'b0;
      nxt_rd      = rd_i;
      nxt_result  = '0;
      nxt_wb      = 1'b0;
      nxt_illegal = 1'b0;
      if (valid_i) begin
         nxt_valid = 1'b1;
         if (is_lui) begin
            nxt_result = imm_ext_i;
            nxt_wb     = (rd_i != 5'd0);
         end else if (is_op_imm || (is_op && !is_m)) begin
            nxt_result = alu_result;
            nxt_wb     = (rd_i != 5'd0);
         end else if (is_m) begin
`ifndef RV32M_EN
            nxt_illegal = 1'b1;
`endif
         end
      end
`ifdef RV32M_EN
      // While the engine owns the stage the slot is a bubble; in DONE the
      // engine's result replaces whatever is still on the inputs.
      if ((state == S_IDLE && start) || state == S_BUSY) begin
         nxt_valid  = 1'b0;
         nxt_wb     = 1'b0;
         nxt_result = '0;
      end else if (state == S_DONE) begin
         nxt_valid   = 1'b1;
         nxt_rd      = m_rd;
         nxt_result  = m_result;
         nxt_wb      = (m_rd != 5'd0);
         nxt_illegal = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_o   <= 1'b0;
         rd_o      <= '0;
         result_o  <= '0;
         wb_en_o   <= 1'b0;
         illegal_o <= 1'b0;
      end else begin
         valid_o   <= nxt_valid;
         rd_o      <= nxt_rd;
         result_o  <= nxt_result;
         wb_en_o   <= nxt_wb;
         illegal_o <= nxt_illegal;
      end
   end

endmodule
